// File: rtl/control_types.sv
// Shared LSU definitions: the address map, the region decode and the access-size decode.
package control_types;

    localparam logic [31:0] ADDR_LEDR   = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEDG   = 32'h1000_1000;
    localparam logic [31:0] ADDR_HEX_LO = 32'h1000_2000;
    localparam logic [31:0] ADDR_HEX_HI = 32'h1000_3000;
    localparam logic [31:0] ADDR_LCD    = 32'h1000_4000;
    localparam logic [31:0] ADDR_SW     = 32'h1001_0000;
    localparam logic [31:0] ADDR_BTN    = 32'h1001_1000;

    typedef enum logic [3:0] {
        REG_DMEM,
        REG_LEDR,
        REG_LEDG,
        REG_HEX_LO,
        REG_HEX_HI,
        REG_LCD,
        REG_SW,
        REG_BTN,
        REG_NONE
    } region_e;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } size_e;

    // DMEM starts at byte 0; each I/O register occupies one aligned word.
    function automatic region_e decode_region(input logic [31:0] addr, input logic [31:0] dmem_bytes);
        if (addr < dmem_bytes) return REG_DMEM;
        case (addr[31:2])
            ADDR_LEDR[31:2]:   return REG_LEDR;
            ADDR_LEDG[31:2]:   return REG_LEDG;
            ADDR_HEX_LO[31:2]: return REG_HEX_LO;
            ADDR_HEX_HI[31:2]: return REG_HEX_HI;
            ADDR_LCD[31:2]:    return REG_LCD;
            ADDR_SW[31:2]:     return REG_SW;
            ADDR_BTN[31:2]:    return REG_BTN;
            default:           return REG_NONE;
        endcase
    endfunction

    function automatic size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b100: return SIZE_BYTE;
            3'b001, 3'b101: return SIZE_HALF;
            default:        return SIZE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] hex_word(input logic [27:0] digits);
        return {1'b0, digits[27:21], 1'b0, digits[20:14], 1'b0, digits[13:7], 1'b0, digits[6:0]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: the output follows the input only after it has differed
// for CYCLES consecutive clocks; any bounce restarts the count.
module btn_debounce #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (btn_i != state_q) begin
            if (cnt_q == LAST) begin
                state_d = btn_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_o = state_q;

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte-addressable DMEM, LED/HEX/LCD registers and synchronized SW/BTN inputs.
// Define LSU_BTN_DEBOUNCE_EN to insert a btn_debounce per button after the synchronizer.
module lsu
    import control_types::*;
#(
    parameter int unsigned DMEM_WORDS      = 512,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [55:0] o_io_hex,
    output logic [31:0] o_io_lcd,
    output logic        o_lsu_err
);

    localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    logic [31:0]      dmem_q [DMEM_WORDS];
    logic [31:0]      ledr_q, ledg_q, lcd_q;
    logic [55:0]      hex_q;
    logic             err_q, err_d;
    logic [31:0]      sw_meta_q, sw_sync_q;
    logic [3:0]       btn_meta_q, btn_sync_q, btn_val;

    region_e          region;
    size_e            size;
    logic             misaligned, wr_ok;
    logic [3:0]       be;
    logic [31:0]      wdata, rword, lane, ld;
    logic [IDX_W-1:0] idx;

    always_comb begin
        region     = decode_region(i_lsu_addr, DMEM_BYTES);
        size       = decode_size(i_funct3);
        idx        = i_lsu_addr[IDX_W+1:2];
        misaligned = ((size == SIZE_HALF) && i_lsu_addr[0]) ||
                     ((size == SIZE_WORD) && (i_lsu_addr[1:0] != 2'b00));
        be    = '0;
        wdata = i_st_data;
        case (size)
            SIZE_BYTE: begin
                be[i_lsu_addr[1:0]] = 1'b1;
                wdata = {4{i_st_data[7:0]}};
            end
            SIZE_HALF: begin
                be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
        wr_ok = i_lsu_wren && !misaligned && !i_rst;
        err_d = err_q | misaligned;
    end

    always_comb begin
        case (region)
            REG_DMEM:   rword = dmem_q[idx];
            REG_LEDR:   rword = ledr_q;
            REG_LEDG:   rword = ledg_q;
            REG_HEX_LO: rword = hex_word(hex_q[27:0]);
            REG_HEX_HI: rword = hex_word(hex_q[55:28]);
            REG_LCD:    rword = lcd_q;
            REG_SW:     rword = sw_sync_q;
            REG_BTN:    rword = {28'b0, btn_val};
            default:    rword = '0;
        endcase
        lane = rword >> {i_lsu_addr[1:0], 3'b000};
        case (size)
            SIZE_BYTE: ld = i_funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SIZE_HALF: ld = i_funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default:   ld = rword;
        endcase
        o_ld_data = misaligned ? '0 : ld;
    end

    // DMEM is deliberately not reset; the write gate still drops stores made under reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok && (region == REG_DMEM)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) dmem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_q      <= '0;
            lcd_q      <= '0;
            err_q      <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= i_io_sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= i_io_btn;
            btn_sync_q <= btn_meta_q;
            err_q      <= err_d;
            if (wr_ok) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        case (region)
                            REG_LEDR:   ledr_q[8*b +: 8]      <= wdata[8*b +: 8];
                            REG_LEDG:   ledg_q[8*b +: 8]      <= wdata[8*b +: 8];
                            REG_HEX_LO: hex_q[7*b +: 7]       <= wdata[8*b +: 7];
                            REG_HEX_HI: hex_q[28 + 7*b +: 7]  <= wdata[8*b +: 7];
                            REG_LCD:    lcd_q[8*b +: 8]       <= wdata[8*b +: 8];
                            default:    ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef LSU_BTN_DEBOUNCE_EN
    for (genvar g = 0; g < 4; g++) begin : g_btn_deb
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
            .clk_i (i_clk),
            .rst_i (i_rst),
            .btn_i (btn_sync_q[g]),
            .btn_o (btn_val[g])
        );
    end
`else
    assign btn_val = btn_sync_q;
    // DEBOUNCE_CYCLES is kept on the interface so both builds share one port/parameter list.
    if (DEBOUNCE_CYCLES == 0) begin : g_deb_cfg_ignored
    end
`endif

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_hex  = hex_q;
    assign o_io_lcd  = lcd_q;
    assign o_lsu_err = err_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DMEM_WORDS, 512, data memory depth in 32-bit words (2 KiB).
- DEBOUNCE_CYCLES, 50000, stable-sample count for the button debouncer.

REQ-002 Ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, single clock, rising edge.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_lsu_addr, in, 32, byte address from the core ALU.
- i_st_data, in, 32, store data (rs2).
- i_lsu_wren, in, 1, store request this cycle.
- i_funct3, in, 3, access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- i_io_sw, in, 32, switches, asynchronous to i_clk.
- i_io_btn, in, 4, buttons, asynchronous to i_clk.
- o_ld_data, out, 32, load result to the writeback mux.
- o_io_ledr, out, 32, red LED register.
- o_io_ledg, out, 32, green LED register.
- o_io_hex, out, 56, eight 7-segment digits; digit n occupies bits [7n+6:7n].
- o_io_lcd, out, 32, LCD register.
- o_lsu_err, out, 1, sticky misaligned-access flag.

Function
REQ-003 Address map (byte addresses):
- DMEM: 0x0000_0000..0x0000_07FF.
- LEDR 0x1000_0000, LEDG 0x1000_1000, HEX0-3 0x1000_2000, HEX4-7 0x1000_3000, LCD 0x1000_4000.
- SW 0x1001_0000, BTN 0x1001_1000.
- All other addresses are unmapped.
REQ-004 Loads are combinational with zero latency: o_ld_data depends only on the current address, i_funct3 and the current storage/register contents.
REQ-005 Stores commit on the rising i_clk edge when i_lsu_wren=1. Only the bytes selected by size and addr[1:0] change.
REQ-006 Load extension: LB and LH sign-extend; LBU and LHU zero-extend; LW returns all 32 bits unchanged.
REQ-007 A load from the same address in the cycle after a store returns the newly stored data.
REQ-008 Misalignment is a halfword access with addr[0]=1, or a word access with addr[1:0]!=00. On a misaligned access:
- stores are suppressed;
- loads return 0;
- o_lsu_err is set on the next edge and holds until reset.
REQ-009 Unmapped accesses: loads return 0; stores are ignored; o_lsu_err is not set.
REQ-010 HEX registers: each byte lane drives one digit, bits [6:0] only. Bit 7 of each lane is write-ignored and reads 0.
REQ-011 SW and BTN are read-only; stores to them are ignored. Reads of the unused BTN bits [31:4] return 0.
REQ-012 i_io_sw and i_io_btn each pass through a two-flop synchronizer. A change at the input is visible to loads 2 clock edges later.
REQ-013 i_funct3 values other than those listed in REQ-002 are treated as a word access.

Reset
REQ-014 While i_rst=1, and immediately on its assertion:
- LEDR, LEDG, HEX, LCD, o_lsu_err and the synchronizer flops are 0;
- the debouncer state and counter are 0.
REQ-015 DMEM contents are not reset. A store in progress during reset is discarded.

Configuration
REQ-016 Macro LSU_BTN_DEBOUNCE_EN:
- Defined: each synchronized button feeds a debouncer with a counter. The debounced bit changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Undefined: BTN reads the synchronized value directly, and no counter logic is built.

Structure
REQ-017 The address-map constants, a region enum (DMEM/LEDR/LEDG/HEX_LO/HEX_HI/LCD/SW/BTN/NONE) and a funct3 size enum belong in the shared control_types package.
REQ-018 One sub-module, btn_debounce, is instantiated once per button. It exists only when LSU_BTN_DEBOUNCE_EN is defined.

Verification
REQ-019 SW to 0x0000_0010 with data 0xDEADBEEF, then LW from 0x10 -> load returns 0xDEADBEEF.
REQ-020 SB of 0x80 to 0x0000_0013, then LB and LBU from 0x13 -> 0xFFFFFF80 and 0x00000080; LW from 0x10 -> 0x80ADBEEF.
REQ-021 SH to 0x0000_0011 -> DMEM unchanged; o_lsu_err=1 after the edge, and it stays 1 until i_rst pulses.
REQ-022 SW of 0xFFFFFFFF to 0x1000_2000 -> o_io_hex[27:0] all ones, o_io_hex[55:28] zero; LW from 0x1000_2000 returns 0x7F7F7F7F. Asserting i_rst mid-test clears o_io_hex without a clock edge.
REQ-023 Set i_io_sw=0x0000_1234 -> LW from 0x1001_0000 returns the old value after 1 edge and 0x1234 after 2 edges.
REQ-024 With LSU_BTN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, btn[0] toggled 1,0,1 then held -> BTN reads 1 exactly 4 cycles after its synchronized value settles, never earlier. Without the macro -> BTN reads 1 after 2 edges.
